// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the iterative restoring divider.
// The master drives a request (start plus operands); the slave reports
// progress (busy/done) and the registered results.
interface seq_divider_if #(
    parameter int N = 8
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider.
// One quotient bit is resolved per clock, MSB first, so a normal division
// takes N iteration edges after the accepting edge and done pulses N+1
// cycles after start was sampled. A zero divisor short-circuits straight
// to the result with quotient all ones, remainder = dividend and the
// div_by_zero flag set. Results are held until the next result or reset.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    // Counter wide enough to hold N-1 with headroom.
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [N-1:0]  quoWork_q, quoWork_d;
    logic [N:0]    remWork_q, remWork_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          divByZero_q, divByZero_d;

    logic [N:0]    remShifted;
    logic [N:0]    remDiff;
    logic          remGe;
    logic [N-1:0]  quoShifted;
    logic          lastIter;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, and record the quotient bit.
    always_comb begin
        remShifted = {remWork_q[N-1:0], quoWork_q[N-1]};
        remGe      = (remShifted >= {1'b0, divisor_q});
        remDiff    = remShifted - {1'b0, divisor_q};
        quoShifted = {quoWork_q[N-2:0], remGe};
        lastIter   = (count_q == CW'(N - 1));
    end

    // Next-state logic: request acceptance, iteration and result capture.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        quoWork_d   = quoWork_q;
        remWork_d   = remWork_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        divByZero_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        divisor_d = bus.divisor;
                        quoWork_d = bus.dividend;
                        remWork_d = '0;
                        count_d   = '0;
                    end
                end
            end

            RUN: begin
                quoWork_d = quoShifted;
                remWork_d = remGe ? remDiff : remShifted;
                count_d   = count_q + CW'(1);
                if (lastIter) begin
                    state_d     = DONE;
                    quotient_d  = quoShifted;
                    remainder_d = remGe ? remDiff[N-1:0] : remShifted[N-1:0];
                    divByZero_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            quoWork_q   <= '0;
            remWork_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            divisor_q   <= divisor_d;
            quoWork_q   <= quoWork_d;
            remWork_q   <= remWork_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: reset, a table of directed vectors,
// hand-written corner sequences, then random traffic against a plain
// arithmetic reference model.
module tb_seq_divider;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] dividend;
        logic [N-1:0] divisor;
        logic [N-1:0] expQ;
        logic [N-1:0] expR;
        logic         expZ;
    } vec_t;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [N-1:0] lastQ;
    logic [N-1:0] lastR;
    logic         lastZ;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // Reference: plain arithmetic, with the zero-divisor convention.
    task automatic refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                            output logic [N-1:0] q, output logic [N-1:0] r,
                            output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // Present a request for exactly one edge, then scramble the operands.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
    endtask

    // Called right after the accepting edge; follows the operation
    // cycle-by-cycle and stops at the sample where done is expected.
    // pokeAt >= 0 injects a start (50/5) during that busy cycle.
    task automatic waitForResult(input logic [N-1:0] b,
                                 input logic [N-1:0] expQ,
                                 input logic [N-1:0] expR,
                                 input logic expZ, input int pokeAt);
        int expLat;
        expLat = (b == 0) ? 0 : N;
        for (int k = 0; k < expLat; k++) begin
            checkOutput("busyRun", 32'(bus.busy), 32'd1);
            checkOutput("doneRun", 32'(bus.done), 32'd0);
            checkOutput("holdQ", 32'(bus.quotient), 32'(lastQ));
            checkOutput("holdR", 32'(bus.remainder), 32'(lastR));
            checkOutput("holdZ", 32'(bus.div_by_zero), 32'(lastZ));
            if (k == pokeAt) begin
                bus.start    = 1'b1;
                bus.dividend = N'(50);
                bus.divisor  = N'(5);
            end
            tick();
            bus.start = 1'b0;
        end
        checkOutput("busyDone", 32'(bus.busy), 32'd0);
        checkOutput("donePulse", 32'(bus.done), 32'd1);
        checkOutput("quotient", 32'(bus.quotient), 32'(expQ));
        checkOutput("remainder", 32'(bus.remainder), 32'(expR));
        checkOutput("divByZero", 32'(bus.div_by_zero), 32'(expZ));
        lastQ = expQ;
        lastR = expR;
        lastZ = expZ;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "Busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, "Done"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [N-1:0] a, b, q, r;
        logic         z;
        int           sel;
        bit           chain;

        checks = 0;
        errors = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs[0] = '{N'(100), N'(7),   N'(14),  N'(2),   1'b0};
        vecs[1] = '{N'(255), N'(1),   N'(255), N'(0),   1'b0};
        vecs[2] = '{N'(3),   N'(200), N'(0),   N'(3),   1'b0};
        vecs[3] = '{N'(5),   N'(0),   N'(255), N'(5),   1'b1};
        vecs[4] = '{N'(10),  N'(3),   N'(3),   N'(1),   1'b0};
        vecs[5] = '{N'(0),   N'(5),   N'(0),   N'(0),   1'b0};
        vecs[6] = '{N'(255), N'(255), N'(1),   N'(0),   1'b0};
        vecs[7] = '{N'(254), N'(255), N'(0),   N'(254), 1'b0};
        vecs[8] = '{N'(128), N'(2),   N'(64),  N'(0),   1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("resetQ", 32'(bus.quotient), 32'd0);
        checkOutput("resetR", 32'(bus.remainder), 32'd0);
        checkOutput("resetZ", 32'(bus.div_by_zero), 32'd0);
        lastQ = '0;
        lastR = '0;
        lastZ = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].dividend, vecs[i].divisor);
            waitForResult(vecs[i].divisor, vecs[i].expQ, vecs[i].expR,
                          vecs[i].expZ, -1);
            tick();
            checkIdle("afterDone");
        end

        // Start while busy is ignored; exactly one done follows
        applyStimulus(N'(200), N'(9));
        waitForResult(N'(9), N'(22), N'(2), 1'b0, 3);
        for (int k = 0; k < N + 2; k++) begin
            tick();
            checkIdle("noSecondDone");
        end

        // Reset in cycle 4 of RUN abandons the division
        applyStimulus(N'(77), N'(4));
        for (int k = 0; k < 3; k++) begin
            checkOutput("busyPreRst", 32'(bus.busy), 32'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle("midRst");
        checkOutput("midRstQ", 32'(bus.quotient), 32'd0);
        checkOutput("midRstR", 32'(bus.remainder), 32'd0);
        checkOutput("midRstZ", 32'(bus.div_by_zero), 32'd0);
        lastQ = '0;
        lastR = '0;
        lastZ = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            tick();
            checkIdle("postRst");
        end
        applyStimulus(N'(77), N'(4));
        waitForResult(N'(4), N'(19), N'(1), 1'b0, -1);
        tick();
        checkIdle("afterRetry");

        // Back-to-back: start held during the done cycle
        applyStimulus(N'(100), N'(7));
        waitForResult(N'(7), N'(14), N'(2), 1'b0, -1);
        applyStimulus(N'(60), N'(6));
        waitForResult(N'(6), N'(10), N'(0), 1'b0, -1);
        tick();
        checkIdle("afterB2B");

        // Random traffic, sometimes chained back-to-back
        for (int i = 0; i < 60; i++) begin
            a   = N'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)
                b = '0;
            else if (sel < 4)
                b = N'($urandom_range(1, 15));
            else
                b = N'($urandom);
            chain = 1'($urandom_range(0, 1));
            refModel(a, b, q, r, z);
            applyStimulus(a, b);
            waitForResult(b, q, r, z, -1);
            if (!chain) begin
                tick();
                checkIdle("randIdle");
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the team's registered adder-tree multiplier.
- Computes quotient and remainder of two N-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath; trades latency (N+1 cycles) for area.

Parameters:
N, 8, operand width in bits (N >= 2); quotient and remainder are N bits each.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only when busy=0
dividend  input  N  unsigned dividend, sampled on the edge that accepts start
divisor  input  N  unsigned divisor, sampled on the edge that accepts start
busy  output  1  high while an accepted division is iterating
done  output  1  one-cycle pulse: quotient/remainder/div_by_zero valid
quotient  output  N  registered quotient
remainder  output  N  registered remainder
div_by_zero  output  1  registered flag, valid with done

Behaviour:
- Interface (decided): one clock clk; rst is synchronous and active-high, evaluated at the rising edge of clk.
- Reset (takes priority over everything, including mid-operation):
  - state=IDLE, busy=0, done=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter and internal registers cleared.
  - Any in-flight division is abandoned with no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Acceptance:
  - start is accepted on an edge where start=1 and state is IDLE or DONE.
  - start while in RUN is ignored entirely; operands are not sampled and the running division is unaffected.
- Accepted start with divisor != 0:
  - Latch dividend and divisor; partial remainder R=0 (N+1 bits); counter=0; go to RUN.
- Accepted start with divisor == 0:
  - Go directly to DONE.
  - Register quotient = all ones, remainder = dividend, div_by_zero = 1.
  - done is high in the cycle after the accepting edge (latency 1).
- RUN iteration (one per edge, MSB first):
  - R = {R[N-1:0], Q[N-1]}; Q shifts left.
  - If R >= divisor: R = R - divisor and Q[0] = 1; else Q[0] = 0.
  - Counter increments each edge.
  - After the Nth iteration edge, go to DONE and register quotient=Q, remainder=R[N-1:0], div_by_zero=0.
- Latency for a normal division:
  - Accepting edge = edge 0.
  - busy high for N cycles (after edges 0 .. N-1).
  - Results registered at edge N; done high in the cycle after edge N, i.e. N+1 cycles after start was sampled.
- DONE handling:
  - In DONE, start=1 is accepted (back-to-back operation).
  - Otherwise return to IDLE after one cycle.
- Output hold:
  - quotient, remainder and div_by_zero hold their last values until the next DONE entry or reset.
  - They do not change during RUN.
- Arithmetic:
  - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
  - Unsigned only; no overflow is possible for divisor != 0.
- Input stability: dividend and divisor may change freely after the accepting edge.

Test Plan:
- Reset, then start with dividend=100, divisor=7 (N=8) -> busy=1 for 8 cycles; done pulse 9 cycles after start with quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=3, divisor=200 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> done in the next cycle, busy never high; quotient=255, remainder=5, div_by_zero=1. A following 10/3 clears the flag (quotient=3, remainder=1, div_by_zero=0).
- Start 200/9, then pulse start with 50/5 while busy -> second request ignored; done once with quotient=22, remainder=2; no second done.
- Start 77/4, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, outputs all zero, no done pulse follows. Then a new start 77/4 gives quotient=19, remainder=1.
- Start 100/7; hold start high with 60/6 during the DONE cycle -> first done shows 14 r 2; second division accepted immediately; second done 9 cycles later shows quotient=10, remainder=0.
